mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/arb_pick.sv | 28 ++
 rtl/mem_arbiter.sv | 110 +++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and lock-state encoding for the two-port RAM arbiter.
package mem_arb_pkg;

   localparam int NPORT  = 2;
   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      LOCKED0  = 2'd1,
      LOCKED1  = 2'd2
   } lock_state_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational two-way picker: turns valids, the last-granted pointer and the
// lock state into a one-hot (or empty) grant vector.
module arb_pick
   import mem_arb_pkg::*;
(
   input  logic [NPORT-1:0] valid_i,
   input  logic             last_i,
   input  logic [1:0]       lock_state_i,
   output logic [NPORT-1:0] grant_o
);

   // A locked port owns the RAM outright; otherwise ties go to the port not granted last.
   always_comb begin
      grant_o = '0;
      case (lock_state_i)
         LOCKED0: grant_o[0] = valid_i[0];
         LOCKED1: grant_o[1] = valid_i[1];
         default: begin
            if (&valid_i) begin
               grant_o = last_i ? 2'b01 : 2'b10;
            end else begin
               grant_o = valid_i;
            end
         end
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Zero-wait two-port arbiter in front of a single registered-read RAM, with a
// per-port lock. Define MEM_ARB_RR_EN for round-robin ties, else port 0 wins.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_LEN = 11
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NPORT-1:0]          req_valid,
   output logic [NPORT-1:0]          req_ready,
   input  logic [NPORT-1:0]          req_we,
   input  logic [NPORT-1:0]          req_lock,
   input  logic [NPORT*ADDR_LEN-1:0] req_addr,
   input  logic [NPORT*WORD_W-1:0]   req_wdata,
   output logic [NPORT-1:0]          rsp_valid,
   output logic [WORD_W-1:0]         rsp_rdata,
   output logic [ADDR_LEN-1:0]       mem_addr,
   output logic                      mem_wr_req,
   output logic [WORD_W-1:0]         mem_wr_data,
   input  logic [WORD_W-1:0]         mem_rd_data
);

   lock_state_e      lock_q, lock_d;
   logic [NPORT-1:0] rsp_pend_q, rsp_pend_d;
   logic [NPORT-1:0] grant_raw;
   logic [NPORT-1:0] grant;
   logic             last_ptr;

`ifdef MEM_ARB_RR_EN
   logic last_q, last_d;

   assign last_d   = (|grant) ? grant[1] : last_q;
   assign last_ptr = last_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end
`else
   // Pretending port 1 always went last makes the picker a fixed port-0 priority.
   assign last_ptr = 1'b1;
`endif

   arb_pick u_pick (
      .valid_i      (req_valid),
      .last_i       (last_ptr),
      .lock_state_i (lock_q),
      .grant_o      (grant_raw)
   );

   assign grant     = rst ? '0 : grant_raw;
   assign req_ready = grant;

   always_comb begin
      mem_addr    = '0;
      mem_wr_data = '0;
      mem_wr_req  = 1'b0;
      for (int i = 0; i < NPORT; i++) begin
         if (grant[i]) begin
            mem_addr    = req_addr[i*ADDR_LEN +: ADDR_LEN];
            mem_wr_data = req_wdata[i*WORD_W +: WORD_W];
            mem_wr_req  = req_we[i];
         end
      end
   end

   // RAM read data lands one cycle after the address, so remember which port asked.
   assign rsp_pend_d = grant & ~req_we;
   assign rsp_valid  = rsp_pend_q;
   assign rsp_rdata  = (|rsp_pend_q) ? mem_rd_data : '0;

   always_comb begin
      lock_d = lock_q;
      case (lock_q)
         UNLOCKED: begin
            if (grant[0] && req_lock[0]) begin
               lock_d = LOCKED0;
            end else if (grant[1] && req_lock[1]) begin
               lock_d = LOCKED1;
            end
         end
         LOCKED0: begin
            if (grant[0] && !req_lock[0]) begin
               lock_d = UNLOCKED;
            end
         end
         LOCKED1: begin
            if (grant[1] && !req_lock[1]) begin
               lock_d = UNLOCKED;
            end
         end
         default: lock_d = UNLOCKED;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lock_q     <= UNLOCKED;
         rsp_pend_q <= '0;
      end else begin
         lock_q     <= lock_d;
         rsp_pend_q <= rsp_pend_d;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural registered-read RAM;
// expectations switch with MEM_ARB_RR_EN to match the build under test.
module tb_mem_arbiter;

   localparam int ADDR_LEN = 11;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   logic [1:0]            req_we;
   logic [1:0]            req_lock;
   logic [2*ADDR_LEN-1:0] req_addr;
   logic [63:0]           req_wdata;
   logic [1:0]            rsp_valid;
   logic [31:0]           rsp_rdata;
   logic [ADDR_LEN-1:0]   mem_addr;
   logic                  mem_wr_req;
   logic [31:0]           mem_wr_data;
   logic [31:0]           mem_rd_data;

   logic [31:0] ram [0:(1<<ADDR_LEN)-1];

   int checkCount = 0;
   int failCount  = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_LEN(ADDR_LEN)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_lock    (req_lock),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .mem_addr    (mem_addr),
      .mem_wr_req  (mem_wr_req),
      .mem_wr_data (mem_wr_data),
      .mem_rd_data (mem_rd_data)
   );

   // Behavioural RAM: write-then-registered-read on the same address edge.
   always @(posedge clk) begin
      if (mem_wr_req) ram[mem_addr] <= mem_wr_data;
      mem_rd_data <= ram[mem_addr];
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checkCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] we, input logic [1:0] lock,
                                input logic [10:0] addr0, input logic [10:0] addr1,
                                input logic [31:0] wd0, input logic [31:0] wd1);
      req_valid = valid;
      req_we    = we;
      req_lock  = lock;
      req_addr  = {addr1, addr0};
      req_wdata = {wd1, wd0};
   endtask

   task automatic goIdle();
      applyStimulus(2'b00, 2'b00, 2'b00, 11'd0, 11'd0, 32'd0, 32'd0);
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic resetDut();
      goIdle();
      rst = 1'b1;
      nextCycle();
      nextCycle();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      for (int i = 0; i < (1 << ADDR_LEN); i++) ram[i] = 32'd0;
      ram[0] = 32'h000000A4;
      ram[3] = 32'h000000DE;
      ram[5] = 32'h000000A1;
      ram[7] = 32'h00000077;

      // Reset values, with a request pending that must not be granted.
      goIdle();
      rst = 1'b1;
      req_valid = 2'b01;
      nextCycle();
      nextCycle();
      checkOutput("rst_ready", 64'(req_ready), 64'd0);
      checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      checkOutput("rst_wr_req", 64'(mem_wr_req), 64'd0);
      checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);

      // Single read granted in the first cycle after reset.
      rst = 1'b0;
      applyStimulus(2'b01, 2'b00, 2'b00, 11'd0, 11'd0, 32'd0, 32'd0);
      #1;
      checkOutput("rd0_ready", 64'(req_ready), 64'h1);
      checkOutput("rd0_mem_addr", 64'(mem_addr), 64'd0);
      checkOutput("rd0_wr_req", 64'(mem_wr_req), 64'd0);
      nextCycle();
      goIdle();
      #1;
      checkOutput("rd0_rsp_valid", 64'(rsp_valid), 64'h1);
      checkOutput("rd0_rsp_rdata", 64'(rsp_rdata), 64'hA4);
      checkOutput("idle_ready", 64'(req_ready), 64'd0);
      checkOutput("idle_mem_addr", 64'(mem_addr), 64'd0);
      nextCycle();
      checkOutput("idle_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("idle_rsp_rdata", 64'(rsp_rdata), 64'd0);

      // Both ports reading every cycle.
      resetDut();
      begin
         logic [1:0] expGrant [0:3];
         for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            expGrant[k] = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            expGrant[k] = 2'b01;
`endif
            if (k > 0) begin
               checkOutput($sformatf("tie_rsp_valid%0d", k-1), 64'(rsp_valid), 64'(expGrant[k-1]));
               checkOutput($sformatf("tie_rsp_rdata%0d", k-1), 64'(rsp_rdata),
                           (expGrant[k-1] == 2'b01) ? 64'hDE : 64'hA1);
            end
            applyStimulus(2'b11, 2'b00, 2'b00, 11'd3, 11'd5, 32'd0, 32'd0);
            #1;
            checkOutput($sformatf("tie_ready%0d", k), 64'(req_ready), 64'(expGrant[k]));
            checkOutput($sformatf("tie_addr%0d", k), 64'(mem_addr),
                        (expGrant[k] == 2'b01) ? 64'd3 : 64'd5);
            nextCycle();
         end
         goIdle();
         checkOutput("tie_rsp_valid3", 64'(rsp_valid), 64'(expGrant[3]));
         checkOutput("tie_rsp_rdata3", 64'(rsp_rdata), (expGrant[3] == 2'b01) ? 64'hDE : 64'hA1);
      end

      // Lock held by port 1 across a read and a write; port 0 stalls meanwhile.
      resetDut();
      applyStimulus(2'b10, 2'b00, 2'b10, 11'd7, 11'd7, 32'd0, 32'd0);
      #1;
      checkOutput("lk_rd1_ready", 64'(req_ready), 64'h2);
      nextCycle();
      checkOutput("lk_rd1_rsp_valid", 64'(rsp_valid), 64'h2);
      checkOutput("lk_rd1_rsp_rdata", 64'(rsp_rdata), 64'h77);
      applyStimulus(2'b01, 2'b00, 2'b00, 11'd7, 11'd7, 32'd0, 32'd0);
      #1;
      checkOutput("lk_idle1_stall_ready", 64'(req_ready), 64'd0);
      nextCycle();
      applyStimulus(2'b11, 2'b10, 2'b00, 11'd7, 11'd7, 32'd0, 32'h12345678);
      #1;
      checkOutput("lk_wr1_ready", 64'(req_ready), 64'h2);
      checkOutput("lk_wr1_wr_req", 64'(mem_wr_req), 64'h1);
      checkOutput("lk_wr1_addr", 64'(mem_addr), 64'd7);
      checkOutput("lk_wr1_wdata", 64'(mem_wr_data), 64'h12345678);
      nextCycle();
      checkOutput("lk_wr1_no_rsp", 64'(rsp_valid), 64'd0);
      applyStimulus(2'b01, 2'b00, 2'b00, 11'd7, 11'd7, 32'd0, 32'd0);
      #1;
      checkOutput("lk_rd0_ready", 64'(req_ready), 64'h1);
      nextCycle();
      goIdle();
      checkOutput("lk_rd0_rsp_valid", 64'(rsp_valid), 64'h1);
      checkOutput("lk_rd0_rsp_rdata", 64'(rsp_rdata), 64'h12345678);

      // Reset arrives while a locking read is granted but before its edge.
      resetDut();
      applyStimulus(2'b10, 2'b00, 2'b10, 11'd0, 11'd3, 32'd0, 32'd0);
      #1;
      checkOutput("rr_pre_ready", 64'(req_ready), 64'h2);
      #5;
      rst = 1'b1;
      #1;
      checkOutput("rr_in_rst_ready", 64'(req_ready), 64'd0);
      nextCycle();
      checkOutput("rr_in_rst_rsp_valid", 64'(rsp_valid), 64'd0);
      rst = 1'b0;
      applyStimulus(2'b11, 2'b00, 2'b00, 11'd3, 11'd5, 32'd0, 32'd0);
      #1;
      checkOutput("rr_post_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("rr_post_tie_ready", 64'(req_ready), 64'h1);
      nextCycle();
      goIdle();
      checkOutput("rr_post_rsp_valid2", 64'(rsp_valid), 64'h1);
      checkOutput("rr_post_rsp_rdata2", 64'(rsp_rdata), 64'hDE);

      // Write then read of the same address back-to-back from port 0.
      resetDut();
      applyStimulus(2'b01, 2'b01, 2'b00, 11'd2, 11'd0, 32'hCAFEF00D, 32'd0);
      #1;
      checkOutput("raw_wr_ready", 64'(req_ready), 64'h1);
      checkOutput("raw_wr_req", 64'(mem_wr_req), 64'h1);
      checkOutput("raw_wr_addr", 64'(mem_addr), 64'd2);
      checkOutput("raw_wr_data", 64'(mem_wr_data), 64'hCAFEF00D);
      nextCycle();
      applyStimulus(2'b01, 2'b00, 2'b00, 11'd2, 11'd0, 32'd0, 32'd0);
      #1;
      checkOutput("raw_wr_no_rsp", 64'(rsp_valid), 64'd0);
      checkOutput("raw_rd_ready", 64'(req_ready), 64'h1);
      checkOutput("raw_rd_wr_req", 64'(mem_wr_req), 64'd0);
      nextCycle();
      goIdle();
      checkOutput("raw_rd_rsp_valid", 64'(rsp_valid), 64'h1);
      checkOutput("raw_rd_rsp_rdata", 64'(rsp_rdata), 64'hCAFEF00D);
      nextCycle();
      checkOutput("raw_after_rsp_valid", 64'(rsp_valid), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
